// File: rtl/goofy_pkg.sv
// goofy_pkg: shared definitions for the GoofyRam arbiter slice.
//   owner_t      - bus owner state encoding (IDLE / CPU / DMA)
//   GOOFY_*_W    - default RAM address/data widths
//   LAST_*       - encoding of the one-bit last_owner flag
//   burst_cnt_w  - burst counter width for a given MAX_BURST
package goofy_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    localparam int GOOFY_ADDR_W = 16;
    localparam int GOOFY_DATA_W = 8;

    localparam logic LAST_CPU = 1'b0;
    localparam logic LAST_DMA = 1'b1;

    // A MAX_BURST of 1 still needs a one-bit register.
    function automatic int burst_cnt_w(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/goofy_arb_burst_counter.sv
// goofy_arb_burst_counter: counts consecutive acked beats of the current
// owner while the other requester is waiting, saturating at MAX_BURST-1.
//   clk, reset    - clock, synchronous active-high reset
//   beat          - current owner has a beat acked this cycle
//   other_wait    - the non-owning requester is requesting
//   owner_change  - owner register changes at the next edge
//   limit_hit     - this acked beat is the last one the owner may take
module goofy_arb_burst_counter
    import goofy_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic beat,
    input  logic other_wait,
    input  logic owner_change,
    output logic limit_hit
);

    localparam int CNT_W = burst_cnt_w(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    logic [CNT_W-1:0] burst_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            burst_cnt <= '0;
        end else if (owner_change || !other_wait) begin
            burst_cnt <= '0;
        end else if (beat && (burst_cnt != CNT_MAX)) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

    assign limit_hit = beat && other_wait && (burst_cnt == CNT_MAX);

endmodule

// File: rtl/goofy_ram_arbiter.sv
// goofy_ram_arbiter: grants the single-port GoofyRam to the CPU or the DMA
// engine, one owner at a time, with bounded bursts and a DMA bus lock.
//   clk, reset                      - clock, synchronous active-high reset
//   cpu_req/we/addr/wdata -> ack    - CPU beat interface, cpu_rdata read data
//   dma_req/we/addr/wdata -> ack    - DMA beat interface, dma_rdata read data
//   dma_lock                        - DMA keeps the bus while it owns it
//   ram_addr, ram_in, sam_save      - RAM address, write data, write enable
//   ram_out                         - RAM combinational read data
module goofy_ram_arbiter
    import goofy_pkg::*;
#(
    parameter int MAX_BURST = 16,
    parameter int ADDR_W    = GOOFY_ADDR_W,
    parameter int DATA_W    = GOOFY_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    input  logic              dma_lock,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_in,
    output logic              sam_save,
    input  logic [DATA_W-1:0] ram_out
);

    owner_t owner;
    owner_t owner_next;
    logic   last_owner;
    logic   beat;
    logic   other_wait;
    logic   owner_change;
    logic   limit_hit;

    assign beat       = ((owner == OWN_CPU) && cpu_req) || ((owner == OWN_DMA) && dma_req);
    assign other_wait = ((owner == OWN_CPU) && dma_req) || ((owner == OWN_DMA) && cpu_req);
    assign owner_change = (owner_next != owner);

    goofy_arb_burst_counter #(
        .MAX_BURST (MAX_BURST)
    ) u_burst_counter (
        .clk          (clk),
        .reset        (reset),
        .beat         (beat),
        .other_wait   (other_wait),
        .owner_change (owner_change),
        .limit_hit    (limit_hit)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= OWN_IDLE;
            last_owner <= LAST_DMA;
        end else begin
            owner <= owner_next;
            if ((owner != OWN_IDLE) && owner_change) begin
                last_owner <= (owner == OWN_DMA) ? LAST_DMA : LAST_CPU;
            end
        end
    end

    // Next-state logic; limit_hit already implies the other side is waiting.
    always_comb begin
        owner_next = owner;
        case (owner)
            OWN_IDLE: begin
                if (cpu_req && dma_req) begin
                    owner_next = (last_owner == LAST_DMA) ? OWN_CPU : OWN_DMA;
                end else if (cpu_req) begin
                    owner_next = OWN_CPU;
                end else if (dma_req) begin
                    owner_next = OWN_DMA;
                end
            end
            OWN_CPU: begin
                if (!cpu_req) begin
                    owner_next = dma_req ? OWN_DMA : OWN_IDLE;
                end else if (limit_hit) begin
                    owner_next = OWN_DMA;
                end
            end
            OWN_DMA: begin
                if (!dma_req) begin
                    owner_next = cpu_req ? OWN_CPU : OWN_IDLE;
                end else if (limit_hit && !dma_lock) begin
                    owner_next = OWN_CPU;
                end
            end
            default: owner_next = OWN_IDLE;
        endcase
    end

    // Output logic: RAM mux and acks. Everything is held at zero while reset
    // is high so a write presented in that cycle never reaches the RAM.
    always_comb begin
        cpu_ack   = 1'b0;
        dma_ack   = 1'b0;
        cpu_rdata = '0;
        dma_rdata = '0;
        ram_addr  = '0;
        ram_in    = '0;
        sam_save  = 1'b0;
        if (!reset) begin
            case (owner)
                OWN_CPU: begin
                    cpu_ack   = cpu_req;
                    ram_addr  = cpu_addr;
                    ram_in    = cpu_wdata;
                    sam_save  = cpu_req & cpu_we;
                    cpu_rdata = ram_out;
                    dma_rdata = ram_out;
                end
                OWN_DMA: begin
                    dma_ack   = dma_req;
                    ram_addr  = dma_addr;
                    ram_in    = dma_wdata;
                    sam_save  = dma_req & dma_we;
                    cpu_rdata = ram_out;
                    dma_rdata = ram_out;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_goofy_ram_arbiter.sv
// tb_goofy_ram_arbiter: self-checking bench for goofy_ram_arbiter with a
// behavioural GoofyRam (negedge commit, combinational read) and a
// per-requester scoreboard of presented beats.
module tb_goofy_ram_arbiter;

    localparam int MB = 16;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_ack, dma_lock;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata, dma_rdata;
    logic [15:0] ram_addr;
    logic [7:0]  ram_in, ram_out;
    logic        sam_save;

    logic [7:0] mem   [0:65535];
    logic [7:0] model [0:65535];

    beat_t cpu_todo[$], dma_todo[$], cpu_exp[$], dma_exp[$];
    beat_t ce, de;
    logic  cpu_shown, dma_shown;
    logic  cpu_acked, dma_acked;
    logic  log_en;
    logic [1:0] ack_hist[$];
    int checks, errors;
    int cpu_acks, dma_acks;

    always #5 clk = ~clk;

    goofy_ram_arbiter #(
        .MAX_BURST (MB),
        .ADDR_W    (16),
        .DATA_W    (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_ack   (dma_ack),
        .dma_rdata (dma_rdata),
        .dma_lock  (dma_lock),
        .ram_addr  (ram_addr),
        .ram_in    (ram_in),
        .sam_save  (sam_save),
        .ram_out   (ram_out)
    );

    // GoofyRam
    assign ram_out = mem[ram_addr];
    always @(negedge clk) if (sam_save) mem[ram_addr] <= ram_in;

    // Scoreboard side: every ack retires the oldest presented beat.
    always @(negedge clk) begin
        cpu_acked = cpu_ack;
        dma_acked = dma_ack;
        if (log_en) ack_hist.push_back({dma_ack, cpu_ack});
        if (cpu_ack || dma_ack) begin
            checks++;
            if (cpu_ack && dma_ack) begin
                errors++;
                $display("FAIL dual_ack: cpu_ack=%b dma_ack=%b, required at most one", cpu_ack, dma_ack);
            end
        end
        if (cpu_ack) begin
            cpu_acks++;
            checks++;
            if (cpu_exp.size() == 0) begin
                errors++;
                $display("FAIL cpu_sb: ack with no beat outstanding");
            end else begin
                ce = cpu_exp.pop_front();
                if (ram_addr !== ce.addr || sam_save !== ce.we ||
                    (ce.we && ram_in !== ce.data) || (!ce.we && cpu_rdata !== model[ce.addr])) begin
                    errors++;
                    $display("FAIL cpu_sb: got addr=%h save=%b in=%h rdata=%h, required addr=%h save=%b data=%h mem=%h",
                             ram_addr, sam_save, ram_in, cpu_rdata, ce.addr, ce.we, ce.data, model[ce.addr]);
                end
                if (ce.we) model[ce.addr] = ce.data;
            end
        end
        if (dma_ack) begin
            dma_acks++;
            checks++;
            if (dma_exp.size() == 0) begin
                errors++;
                $display("FAIL dma_sb: ack with no beat outstanding");
            end else begin
                de = dma_exp.pop_front();
                if (ram_addr !== de.addr || sam_save !== de.we ||
                    (de.we && ram_in !== de.data) || (!de.we && dma_rdata !== model[de.addr])) begin
                    errors++;
                    $display("FAIL dma_sb: got addr=%h save=%b in=%h rdata=%h, required addr=%h save=%b data=%h mem=%h",
                             ram_addr, sam_save, ram_in, dma_rdata, de.addr, de.we, de.data, model[de.addr]);
                end
                if (de.we) model[de.addr] = de.data;
            end
        end
    end

    // One clock: retire acked beats, present the next ones (posedge + 1).
    task automatic cycle();
        @(posedge clk);
        #1;
        if (cpu_acked && cpu_shown) begin
            void'(cpu_todo.pop_front());
            cpu_shown = 1'b0;
        end
        if (dma_acked && dma_shown) begin
            void'(dma_todo.pop_front());
            dma_shown = 1'b0;
        end
        if (!cpu_shown && cpu_todo.size() > 0) begin
            cpu_exp.push_back(cpu_todo[0]);
            cpu_shown = 1'b1;
        end
        if (!dma_shown && dma_todo.size() > 0) begin
            dma_exp.push_back(dma_todo[0]);
            dma_shown = 1'b1;
        end
        cpu_req   = cpu_shown;
        cpu_we    = cpu_shown ? cpu_todo[0].we   : 1'b0;
        cpu_addr  = cpu_shown ? cpu_todo[0].addr : 16'h0;
        cpu_wdata = cpu_shown ? cpu_todo[0].data : 8'h0;
        dma_req   = dma_shown;
        dma_we    = dma_shown ? dma_todo[0].we   : 1'b0;
        dma_addr  = dma_shown ? dma_todo[0].addr : 16'h0;
        dma_wdata = dma_shown ? dma_todo[0].data : 8'h0;
    endtask

    task automatic drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (!cpu_shown && !dma_shown && cpu_todo.size() == 0 && dma_todo.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        cycle();
        cycle();
    endtask

    task automatic withdraw_all();
        cpu_todo.delete(); dma_todo.delete();
        cpu_exp.delete();  dma_exp.delete();
        cpu_shown = 1'b0;  dma_shown = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    endtask

    task automatic do_reset();
        withdraw_all();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            #3;
            checks++;
            if ({cpu_ack, dma_ack, sam_save, ram_addr, ram_in} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: ack=%b%b save=%b addr=%h in=%h, required all 0",
                         cpu_ack, dma_ack, sam_save, ram_addr, ram_in);
            end
        end
        reset = 1'b0;
        cycle();
        #3;
        checks++;
        if ({cpu_ack, dma_ack, sam_save, ram_addr, ram_in} !== '0) begin
            errors++;
            $display("FAIL post_reset_outputs: ack=%b%b save=%b addr=%h in=%h, required all 0",
                     cpu_ack, dma_ack, sam_save, ram_addr, ram_in);
        end
    endtask

    task automatic test_cpu_write_read();
        bit got, ok;
        cpu_todo.push_back('{1'b1, 16'h1234, 8'hAB});
        cycle();
        #3;
        checks++;
        if (cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL cpu_latency_req_cycle: cpu_ack=%b, required 0", cpu_ack);
        end
        cycle();
        #3;
        checks++;
        if (cpu_ack !== 1'b1 || sam_save !== 1'b1 || ram_addr !== 16'h1234 || ram_in !== 8'hAB) begin
            errors++;
            $display("FAIL cpu_write: ack=%b save=%b addr=%h in=%h, required 1 1 1234 ab",
                     cpu_ack, sam_save, ram_addr, ram_in);
        end
        cpu_todo.push_back('{1'b0, 16'h1234, 8'h00});
        got = 1'b0;
        cycle();
        for (int i = 0; i < 5; i++) begin
            #3;
            if (cpu_ack === 1'b1) begin
                got = 1'b1;
                checks++;
                if (cpu_rdata !== 8'hAB) begin
                    errors++;
                    $display("FAIL cpu_readback: rdata=%h, required ab", cpu_rdata);
                end
                break;
            end
            cycle();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL cpu_read_timeout: no ack in 5 cycles, required ack");
        end
        drain(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL cpu_drain: beats left %0d, required 0", cpu_todo.size());
        end
    endtask

    task automatic test_tie_handoff();
        bit ok;
        logic [1:0] req_seq[8];
        req_seq = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cpu_todo.push_back('{1'b1, 16'h0100 + 16'(i), 8'($urandom)});
            dma_todo.push_back('{1'b1, 16'h0200 + 16'(i), 8'($urandom)});
        end
        ack_hist.delete();
        cycle();
        log_en = 1'b1;
        drain(40, ok);
        log_en = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL tie_drain: beats left cpu=%0d dma=%0d, required 0", cpu_todo.size(), dma_todo.size());
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= ack_hist.size() || ack_hist[i] !== req_seq[i]) begin
                errors++;
                $display("FAIL tie_sequence[%0d]: {dma,cpu}ack=%b, required %b", i,
                         (i < ack_hist.size()) ? ack_hist[i] : 2'bxx, req_seq[i]);
            end
        end
    endtask

    task automatic test_burst_fairness();
        bit ok;
        int bad, c0, d0;
        logic [1:0] want;
        c0 = cpu_acks;
        d0 = dma_acks;
        for (int i = 0; i < 40; i++) begin
            cpu_todo.push_back('{1'b1, 16'h2000 + 16'(i), 8'($urandom)});
            dma_todo.push_back('{1'b1, 16'h3000 + 16'(i), 8'($urandom)});
        end
        ack_hist.delete();
        cycle();
        log_en = 1'b1;
        drain(300, ok);
        log_en = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL burst_drain: beats left cpu=%0d dma=%0d, required 0", cpu_todo.size(), dma_todo.size());
        end
        bad = 0;
        for (int i = 1; i <= 4 * MB; i++) begin
            want = ((((i - 1) / MB) % 2) == 0) ? 2'b01 : 2'b10;
            if (i >= ack_hist.size() || ack_hist[i] !== want) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL burst_alternation: %0d of %0d cycles off pattern, required 0", bad, 4 * MB);
        end
        checks++;
        if (cpu_acks - c0 != 40 || dma_acks - d0 != 40) begin
            errors++;
            $display("FAIL burst_totals: cpu=%0d dma=%0d acks, required 40 40", cpu_acks - c0, dma_acks - d0);
        end
    endtask

    task automatic test_dma_lock();
        bit ok, got;
        int c0, d0, waited;
        dma_lock = 1'b1;
        for (int i = 0; i < 100; i++) dma_todo.push_back('{1'b1, 16'h4000 + 16'(i), 8'($urandom)});
        c0 = cpu_acks;
        d0 = dma_acks;
        cycle();
        for (int i = 0; i < 20; i++) cpu_todo.push_back('{1'b0, 16'h2000 + 16'(i), 8'h00});
        for (int i = 0; i < 40; i++) cycle();
        #6;
        checks++;
        if (dma_acks - d0 != 40 || cpu_acks - c0 != 0) begin
            errors++;
            $display("FAIL lock_hold: dma=%0d cpu=%0d acks, required 40 0", dma_acks - d0, cpu_acks - c0);
        end
        cycle();
        dma_lock = 1'b0;
        got = 1'b0;
        waited = 0;
        for (int i = 0; i < 17; i++) begin
            #6;
            if (cpu_acked) begin
                got = 1'b1;
                break;
            end
            waited++;
            cycle();
        end
        checks++;
        if (!got || waited > MB) begin
            errors++;
            $display("FAIL lock_release: cpu acked=%b after %0d cycles, required within %0d", got, waited, MB);
        end
        drain(400, ok);
        checks++;
        if (!ok || cpu_exp.size() != 0 || dma_exp.size() != 0) begin
            errors++;
            $display("FAIL lock_drain: left cpu=%0d dma=%0d, required 0", cpu_todo.size(), dma_todo.size());
        end
    endtask

    task automatic test_reset_mid_write();
        dma_todo.push_back('{1'b1, 16'h0005, 8'h77});
        cycle();
        cycle();
        reset = 1'b1;
        #3;
        checks++;
        if (sam_save !== 1'b0 || dma_ack !== 1'b0 || cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_write_cycle: save=%b dma_ack=%b cpu_ack=%b, required 0 0 0", sam_save, dma_ack, cpu_ack);
        end
        cycle();
        withdraw_all();
        reset = 1'b0;
        #3;
        checks++;
        if (dma_ack !== 1'b0 || cpu_ack !== 1'b0 || sam_save !== 1'b0) begin
            errors++;
            $display("FAIL reset_next_cycle: dma_ack=%b cpu_ack=%b save=%b, required 0 0 0", dma_ack, cpu_ack, sam_save);
        end
        cycle();
        cycle();
        checks++;
        if (mem[16'h0005] !== 8'h00) begin
            errors++;
            $display("FAIL reset_dropped_write: mem[0005]=%h, required 00", mem[16'h0005]);
        end
    endtask

    task automatic test_idle();
        int bad;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            #3;
            if (ram_addr !== '0 || sam_save !== 1'b0 || cpu_ack !== 1'b0 || dma_ack !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_bus: %0d of 100 cycles non-zero, required 0", bad);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; cpu_acks = 0; dma_acks = 0;
        cpu_acked = 1'b0; dma_acked = 1'b0; log_en = 1'b0;
        dma_lock = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            mem[i]   = 8'h00;
            model[i] = 8'h00;
        end
        withdraw_all();

        test_reset();
        test_cpu_write_read();
        test_tie_handoff();
        test_burst_fairness();
        test_dma_lock();
        test_reset_mid_write();
        test_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/goofy_ram_arbiter.md
# goofy_ram_arbiter

Two-requester arbiter that shares the single-port 64K×8 GoofyRam between the CPU core and the DMA/loader engine. It sits directly in front of the RAM and is the only driver of `ram_addr`, `ram_in` and `sam_save`. It grants one owner at a time, bounds CPU/DMA bursts to prevent starvation, and lets the DMA lock the bus for atomic sequences.

## Interface
Parameters:
- `MAX_BURST`, 16: max consecutive acked beats for one owner while the other requester waits (1..255).
- `ADDR_W`, 16: RAM address width.
- `DATA_W`, 8: RAM data width.

Ports:
- `clk`  in  1  system clock; all state on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  CPU access request (level, one beat per acked cycle).
- `cpu_we`  in  1  CPU write (1) / read (0).
- `cpu_addr`  in  ADDR_W  CPU address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_ack`  out  1  beat accepted this cycle.
- `cpu_rdata`  out  DATA_W  read data, valid when `cpu_ack` && !`cpu_we`.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_ack`, `dma_rdata`: same as the CPU signals, for the DMA.
- `dma_lock`  in  1  while high, DMA keeps ownership regardless of burst count.
- `ram_addr`  out  ADDR_W  to RAM address.
- `ram_in`  out  DATA_W  to RAM write data.
- `sam_save`  out  1  to RAM write enable (RAM commits on negedge).
- `ram_out`  in  DATA_W  RAM combinational read data.

## Operation
- States: IDLE, CPU, DMA (registered `owner`), plus `last_owner` (1 bit) and `burst_cnt`.
- IDLE: no ack. Next state:
  - `cpu_req` only → CPU.
  - `dma_req` only → DMA.
  - both → the one ≠ `last_owner`.
  - neither → IDLE.
- Owner state X, other requester Y:
  - `X_ack = X_req`, combinational.
  - RAM mux selects X: `ram_addr = X_addr`, `ram_in = X_wdata`, `sam_save = X_req & X_we`.
- Leaving X:
  - `X_req` low → Y if `Y_req`, else IDLE.
  - `X_req` high, `Y_req` high, `burst_cnt == MAX_BURST-1` on an acked beat, and not (X=DMA && `dma_lock`) → Y.
  - Otherwise stay.
  - On leaving X, set `last_owner` = X.
- Owner handoff is direct (X→Y, no IDLE bubble). Y is acked the cycle after X's last beat.
- `burst_cnt`:
  - Increments on each acked beat while the other requester is waiting.
  - Clears on owner change or when the other requester is not waiting.
  - Saturates at MAX_BURST-1.
  - Width: clog2(MAX_BURST).
- `dma_lock` is honoured only while DMA owns the bus. It never preempts a CPU owner.
- `cpu_rdata` = `dma_rdata` = `ram_out` (broadcast); meaningful only with own ack and read.
- In IDLE: `ram_addr` = 0, `ram_in` = 0, `sam_save` = 0.

## Timing
- Reset values: `owner`=IDLE, `last_owner`=DMA (CPU wins the first tie), `burst_cnt`=0.
- All outputs are 0 during and after reset until the first grant.
- `sam_save` is forced 0 in any cycle with `reset` high. A write presented in that cycle is dropped, not deferred.
- Latency from IDLE: request in cycle n → ack in cycle n+1. Back-to-back beats to the current owner: 1 per cycle, no bubbles.
- Requesters drive `req`/`we`/`addr`/`wdata` from posedge registers. These signals are held until ack and are stable through the negedge write.
- Read data is valid combinationally in the ack cycle. The requester samples it at the next posedge.
- Dropping `req` without ack withdraws the request; no side effects.
- Reset mid-burst: ownership returns to IDLE the next cycle and the burst is lost. The requester re-requests.

## Structure
- Shared package `goofy_pkg`:
  - owner state encoding (`OWN_IDLE`=2'd0, `OWN_CPU`=2'd1, `OWN_DMA`=2'd2);
  - `GOOFY_ADDR_W`=16, `GOOFY_DATA_W`=8.
- One natural sub-module: `goofy_arb_burst_counter`. It contains the saturating counter, clear/increment logic and the `limit_hit` output.
- Keep the RAM mux inline in the arbiter.

## Test plan
- Reset, then `cpu_req`=1 write 0x1234←0xAB: `cpu_ack` first high 1 cycle after req, with `sam_save`=1, `ram_addr`=0x1234, `ram_in`=0xAB. A later CPU read of 0x1234 returns 0xAB.
- Both `req` rise in the same cycle after reset: CPU is granted first. Cycle after CPU drops req: DMA is acked with no IDLE cycle between.
- CPU streams continuously while DMA waits, `MAX_BURST`=16: exactly 16 CPU acks, then 16 DMA acks, alternating. No requester waits more than 16 cycles.
- DMA owns with `dma_lock`=1 for 40 beats while `cpu_req` is held: 40 DMA acks and 0 CPU acks. Lock drops → CPU acked within 16 further cycles.
- `reset` asserted in the cycle of a DMA write to 0x0005 (old 0x00, new 0x77): `sam_save`=0, memory[0x0005] stays 0x00, all acks are 0 the next cycle.
- Idle bus with no requests: `ram_addr`=0, `sam_save`=0, both acks 0 for 100 cycles.
